apb_master_arbiter: RTL and testbench

- Shares one APB master port (psel[15:0], penable, paddr, prwd, pwdata / pready, prdata, pslverr) between NUM_REQ requesters.
- Round-robin arbitration, slot decode of paddr into one-hot psel, SETUP/ACCESS sequencing, pready wait-state handling and wait-state timeout.
- Sits between the testbench/firmware-model requesters and the APB slave fabric (UART, GPIO, interrupt controller).

---
 rtl/apb_arb_pkg.sv | 12 +
 rtl/apb_rr_arbiter.sv | 31 +++
 rtl/apb_master_arbiter.sv | 152 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    localparam int SEL_WIDTH = 4;

    function automatic logic [15:0] onehot16(input logic [SEL_WIDTH-1:0] idx);
        return 16'h1 << idx;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: grants the first active request strictly after the pointer, wrapping.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && !found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters,
// with slot decode, SETUP/ACCESS sequencing, wait states and wait-state timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int PADDR_WIDTH    = 32,
    parameter int PWDATA_WIDTH   = 8,
    parameter int PRDATA_WIDTH   = PWDATA_WIDTH,
    parameter int NUM_SLAVES     = 16,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            pclock,
    input  logic                            preset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*PWDATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [PRDATA_WIDTH-1:0]         rsp_rdata,
    output logic                            rsp_err,
    output logic                            rsp_timeout,
    output logic [PADDR_WIDTH-1:0]          paddr,
    output logic                            prwd,
    output logic [PWDATA_WIDTH-1:0]         pwdata,
    output logic                            penable,
    output logic [15:0]                     psel,
    input  logic                            pready,
    input  logic [PRDATA_WIDTH-1:0]         prdata,
    input  logic                            pslverr
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, own_q, own_d, gnt_idx;
    logic [NUM_REQ-1:0]      gnt;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d, gsel;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d, gaddr;
    logic                    prwd_q, prwd_d;
    logic [PWDATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [PRDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
    logic                    dec_ok, timed_out;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .en_i     (state_q == IDLE),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx)
    );

    assign gaddr     = req_addr[gnt_idx*PADDR_WIDTH +: PADDR_WIDTH];
    assign gsel      = gaddr[SEL_LSB +: SEL_WIDTH];
    assign dec_ok    = int'(gsel) < NUM_SLAVES;
    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        sel_d       = sel_q;
        cnt_d       = '0;
        paddr_d     = paddr_q;
        prwd_d      = prwd_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_to_d    = 1'b0;
        case (state_q)
            IDLE: if (|gnt) begin
                ptr_d    = gnt_idx;
                own_d    = gnt_idx;
                sel_d    = gsel;
                paddr_d  = gaddr;
                prwd_d   = req_write[gnt_idx];
                pwdata_d = req_wdata[gnt_idx*PWDATA_WIDTH +: PWDATA_WIDTH];
                // Undecodable slot: answer with an error without touching the bus
                if (dec_ok) state_d = SETUP;
                else begin
                    rsp_valid_d = gnt;
                    rsp_err_d   = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (pready) begin
                state_d     = IDLE;
                rsp_valid_d = NUM_REQ'(1) << own_q;
                rsp_err_d   = pslverr;
                rsp_rdata_d = prwd_q ? '0 : prdata;
            end else if (timed_out) begin
                state_d     = IDLE;
                rsp_valid_d = NUM_REQ'(1) << own_q;
                rsp_err_d   = 1'b1;
                rsp_to_d    = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            own_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            prwd_q      <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            own_q       <= own_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            prwd_q      <= prwd_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign req_ready   = gnt;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;
    assign paddr       = paddr_q;
    assign prwd        = prwd_q;
    assign pwdata      = pwdata_q;
    assign penable     = state_q == ACCESS;
    assign psel        = state_q == IDLE ? 16'h0 : onehot16(sel_q);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of grant, bus sequencing, wait states, errors and reset.
module tb_apb_master_arbiter;

    logic         pclock = 1'b0, preset = 1'b0;
    logic [3:0]   req_valid = '0, req_write = '0;
    logic [127:0] req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_ready, rsp_valid;
    logic [7:0]   rsp_rdata, pwdata;
    logic         rsp_err, rsp_timeout, prwd, penable;
    logic [31:0]  paddr;
    logic [15:0]  psel;
    logic         pready = 1'b0, pslverr = 1'b0;
    logic [7:0]   prdata = '0;
    int           checks = 0, failures = 0, n;

    apb_master_arbiter #(
        .NUM_REQ(4), .PADDR_WIDTH(32), .PWDATA_WIDTH(8), .PRDATA_WIDTH(8),
        .NUM_SLAVES(8), .SEL_LSB(12), .TIMEOUT_CYCLES(255)
    ) dut (
        .pclock(pclock), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .prwd(prwd), .pwdata(pwdata), .penable(penable), .psel(psel),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclock = ~pclock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge pclock);
        #1;
    endtask

    task automatic setreq(input int i, input logic w, input logic [31:0] a, input logic [7:0] d);
        req_write[i]         = w;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*8 +: 8]  = d;
    endtask

    initial begin
        repeat (2) nxt();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        preset = 1'b1;
        nxt();
        // single read, zero wait states
        setreq(0, 1'b0, 32'h2004, 8'h00);
        prdata = 8'hA5; pready = 1'b1; req_valid = 4'b0001;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        chk("t1_c0_psel", psel, 0);
        nxt(); req_valid = '0;
        chk("t1_c1_psel", psel, 16'h0004);
        chk("t1_c1_penable", penable, 0);
        chk("t1_c1_paddr", paddr, 32'h2004);
        nxt();
        chk("t1_c2_psel", psel, 16'h0004);
        chk("t1_c2_penable", penable, 1);
        chk("t1_c2_rsp", rsp_valid, 0);
        nxt();
        chk("t1_c3_psel", psel, 0);
        chk("t1_c3_penable", penable, 0);
        chk("t1_c3_rsp", rsp_valid, 4'b0001);
        chk("t1_c3_rdata", rsp_rdata, 8'hA5);
        chk("t1_c3_err", rsp_err, 0);
        nxt();
        chk("t1_c4_rsp", rsp_valid, 0);
        // write with three wait states
        pready = 1'b0; prdata = 8'h77;
        setreq(1, 1'b1, 32'h3010, 8'h5C); req_valid = 4'b0010;
        #1;
        chk("t2_grant", req_ready, 4'b0010);
        nxt(); req_valid = '0;
        chk("t2_setup_psel", psel, 16'h0008);
        chk("t2_setup_penable", penable, 0);
        for (int c = 0; c < 4; c++) begin
            nxt();
            if (c == 3) pready = 1'b1;
            chk("t2_penable", penable, 1);
            chk("t2_psel", psel, 16'h0008);
            chk("t2_paddr", paddr, 32'h3010);
            chk("t2_pwdata", pwdata, 8'h5C);
            chk("t2_prwd", prwd, 1);
            chk("t2_rsp_early", rsp_valid, 0);
        end
        nxt(); pready = 1'b0;
        chk("t2_rsp", rsp_valid, 4'b0010);
        chk("t2_rdata", rsp_rdata, 0);
        chk("t2_err", rsp_err, 0);
        chk("t2_penable_off", penable, 0);
        chk("t2_paddr_hold", paddr, 32'h3010);
        // decode error on slot 9 with only 8 slaves
        setreq(3, 1'b0, 32'h9000, 8'h00); req_valid = 4'b1000;
        #1;
        chk("t5_grant", req_ready, 4'b1000);
        nxt(); req_valid = '0;
        chk("t5_psel", psel, 0);
        chk("t5_penable", penable, 0);
        chk("t5_rsp", rsp_valid, 4'b1000);
        chk("t5_err", rsp_err, 1);
        chk("t5_to", rsp_timeout, 0);
        chk("t5_rdata", rsp_rdata, 0);
        chk("t5_paddr", paddr, 32'h9000);
        nxt();
        chk("t5_psel_after", psel, 0);
        chk("t5_rsp_after", rsp_valid, 0);
        // slave error on a valid slot
        setreq(0, 1'b0, 32'h2008, 8'h00);
        prdata = 8'h3C; pslverr = 1'b1; pready = 1'b1; req_valid = 4'b0001;
        #1;
        chk("t5b_grant", req_ready, 4'b0001);
        nxt(); req_valid = '0;
        nxt(); nxt();
        chk("t5b_rsp", rsp_valid, 4'b0001);
        chk("t5b_err", rsp_err, 1);
        chk("t5b_to", rsp_timeout, 0);
        chk("t5b_rdata", rsp_rdata, 8'h3C);
        pslverr = 1'b0;
        // timeout: pready never comes
        pready = 1'b0;
        setreq(2, 1'b0, 32'h4000, 8'h00); req_valid = 4'b0100;
        #1;
        chk("t4_grant", req_ready, 4'b0100);
        nxt(); req_valid = '0;
        chk("t4_setup_psel", psel, 16'h0010);
        nxt();
        n = 0;
        while (penable === 1'b1 && n < 400) begin
            n++;
            nxt();
        end
        chk("t4_access_cycles", n, 255);
        chk("t4_psel", psel, 0);
        chk("t4_rsp", rsp_valid, 4'b0100);
        chk("t4_err", rsp_err, 1);
        chk("t4_to", rsp_timeout, 1);
        // reset in the middle of ACCESS
        nxt();
        setreq(1, 1'b0, 32'h1000, 8'h00); req_valid = 4'b0010;
        #1;
        chk("t6_grant", req_ready, 4'b0010);
        nxt(); req_valid = '0;
        nxt();
        chk("t6_penable", penable, 1);
        #1; preset = 1'b0; #1;
        chk("t6_async_psel", psel, 0);
        chk("t6_async_penable", penable, 0);
        nxt();
        chk("t6_rsp", rsp_valid, 0);
        nxt();
        // all requesters continuously valid after release
        for (int i = 0; i < 4; i++) setreq(i, 1'b0, 32'h1000, 8'h00);
        pready = 1'b1; req_valid = 4'hF; preset = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready == 0 && n < 10) begin
                nxt();
                n++;
            end
            chk("rr_grant", req_ready, 1 << (g % 4));
            chk("rr_rsp", rsp_valid, g == 0 ? 0 : 1 << ((g - 1) % 4));
            nxt();
        end
        req_valid = '0;
        repeat (3) nxt();
        chk("end_psel", psel, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
